// File: rtl/trap_sel.sv
// Trap selector for the M stage: picks one interrupt or exception per cycle,
// reports its cause, and runs the WFI wait/flush state machine.
module trap_sel #(
    parameter int S_SUPPORTED = 1,
    parameter int CAUSE_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallW,
    input  logic               InstrValidM,
    input  logic               IllegalInstrFaultM,
    input  logic               EcallFaultM,
    input  logic               BreakpointFaultM,
    input  logic               RetM,
    input  logic               wfiM,
    input  logic [1:0]         PrivilegeModeW,
    input  logic [11:0]        PendingIntsM,
    input  logic [11:0]        MIDELEG,
    input  logic               STATUS_MIE,
    input  logic               STATUS_SIE,
    output logic               TrapM,
    output logic               InterruptM,
    output logic [CAUSE_W-1:0] CauseM,
    output logic               WFIStallM,
    output logic               RetCommitM
);

    typedef enum logic [1:0] {RUN, WAIT, HOLD} state_t;

    state_t      state;
    logic [11:0] deleg;
    logic [11:0] en_ints;
    logic        m_en;
    logic        s_en;
    logic        int_any;
    logic [3:0]  int_code;
    logic        wfi_exit;

    // Fixed interrupt priority: 11, 3, 7, 9, 1, 5.
    function automatic logic [3:0] int_pick(input logic [11:0] ints);
        logic [3:0] code;
        code = 4'd0;
        if      (ints[11]) code = 4'd11;
        else if (ints[3])  code = 4'd3;
        else if (ints[7])  code = 4'd7;
        else if (ints[9])  code = 4'd9;
        else if (ints[1])  code = 4'd1;
        else if (ints[5])  code = 4'd5;
        return code;
    endfunction

    assign deleg   = (S_SUPPORTED != 0) ? MIDELEG : 12'h000;
    assign m_en    = (PrivilegeModeW != 2'b11) | STATUS_MIE;
    assign s_en    = (PrivilegeModeW == 2'b00) | ((PrivilegeModeW == 2'b01) & STATUS_SIE);
    // Only the six standard interrupt lines participate; the rest are masked off.
    assign en_ints = PendingIntsM & 12'hAAA &
                     ((~deleg & {12{m_en}}) | (deleg & {12{s_en}}));
    assign int_any  = |en_ints;
    assign int_code = int_pick(en_ints);

    always_comb begin
        TrapM      = 1'b0;
        InterruptM = 1'b0;
        CauseM     = '0;
        wfi_exit   = 1'b0;
        if (!reset && !StallW) begin
            case (state)
                RUN: begin
                    if (int_any) begin
                        TrapM      = 1'b1;
                        InterruptM = 1'b1;
                        CauseM     = CAUSE_W'(int_code);
                    end else if (InstrValidM && BreakpointFaultM) begin
                        TrapM  = 1'b1;
                        CauseM = CAUSE_W'(3);
                    end else if (InstrValidM && IllegalInstrFaultM) begin
                        TrapM  = 1'b1;
                        CauseM = CAUSE_W'(2);
                    end else if (InstrValidM && EcallFaultM) begin
                        TrapM  = 1'b1;
                        CauseM = CAUSE_W'(4'd8 + {2'b00, PrivilegeModeW});
                    end
                end
                WAIT: begin
                    // The decoder signals a WFI timeout through the illegal flag.
                    if (IllegalInstrFaultM) begin
                        TrapM  = 1'b1;
                        CauseM = CAUSE_W'(2);
                    end else if (int_any) begin
                        TrapM      = 1'b1;
                        InterruptM = 1'b1;
                        CauseM     = CAUSE_W'(int_code);
                    end else if (PendingIntsM != 12'h000) begin
                        wfi_exit = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign WFIStallM  = (state == WAIT) & ~TrapM & ~wfi_exit;
    assign RetCommitM = RetM & InstrValidM & ~TrapM & ~StallW & ~reset & (state != HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else if (!StallW) begin
            case (state)
                RUN: begin
                    if (TrapM)                   state <= HOLD;
                    else if (wfiM && InstrValidM) state <= WAIT;
                end
                WAIT: begin
                    if (TrapM)         state <= HOLD;
                    else if (wfi_exit) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/trap_sel.md
Name: trap_sel

Overview:
- Sits directly downstream of the privileged-instruction decoder in the M stage.
- Consumes the decoder's fault flags (illegal, ecall, breakpoint) and its return and WFI indications, plus the pending/enabled interrupt vector from the CSR block.
- Selects one trap per cycle with its cause code, and runs the WFI wait state machine that stalls the pipeline until an interrupt arrives or the decoder reports a WFI timeout.

Parameters:
- S_SUPPORTED, 1, supervisor mode present; when 0, delegation is ignored and every interrupt is M-level.
- CAUSE_W, 5, width of cause code (excluding interrupt bit).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- StallW  in  1  writeback stall; the FSM and trap commit hold while high
- InstrValidM  in  1  valid instruction in M
- IllegalInstrFaultM  in  1  from decoder (includes WFI timeout)
- EcallFaultM  in  1  from decoder
- BreakpointFaultM  in  1  from decoder
- RetM  in  1  mret/sret from decoder
- wfiM  in  1  WFI in M, from decoder
- PrivilegeModeW  in  2  current privilege (U=00, S=01, M=11)
- PendingIntsM  in  12  mip & mie
- MIDELEG  in  12  interrupt delegation
- STATUS_MIE  in  1  M-mode global interrupt enable
- STATUS_SIE  in  1  S-mode global interrupt enable
- TrapM  out  1  take trap this cycle
- InterruptM  out  1  trap is an interrupt
- CauseM  out  CAUSE_W  cause code
- WFIStallM  out  1  hold pipeline in WFI wait
- RetCommitM  out  1  RetM qualified, no trap

Behaviour:
- Reset: state=RUN; TrapM=0, InterruptM=0, CauseM=0, WFIStallM=0, RetCommitM=0.
- Interrupt enable:
  - Bit i not delegated (MIDELEG[i]=0 or S_SUPPORTED=0): enabled if priv<M, or priv==M & STATUS_MIE.
  - Bit i delegated: enabled if priv==U, or priv==S & STATUS_SIE; never taken in M.
- Interrupt priority (highest first): 11, 3, 7, 9, 1, 5. Other bits are ignored.
- Exception priority (only when InstrValidM): Breakpoint (cause 3) > Illegal (2) > Ecall (8 + priv: U→8, S→9, M→11).
- Interrupts beat exceptions.
- TrapM is combinational in RUN/WAIT: asserted when (any enabled interrupt or any qualified exception) & ~StallW & state!=HOLD.
  - InterruptM and CauseM are valid only while TrapM=1; otherwise CauseM=0.
- RetCommitM = RetM & InstrValidM & ~TrapM & ~StallW.
- FSM states: RUN, WAIT, HOLD.
  - RUN: if TrapM → HOLD. Else if wfiM & InstrValidM & ~StallW → WAIT.
  - WAIT: WFIStallM=1.
    - IllegalInstrFaultM (timeout) → trap cause 2, WFIStallM=0, → HOLD.
    - Else any enabled interrupt → trap, → HOLD.
    - Else PendingIntsM!=0 (pending but not enabled) → WFIStallM=0, WFI retires, → RUN.
    - Else stay.
  - HOLD: one cycle during pipeline flush. TrapM=0, RetCommitM=0, WFIStallM=0 → RUN. Inputs are ignored.
- StallW=1 in any state: state unchanged; TrapM=0; WFIStallM keeps its WAIT value.
- Simultaneous wfiM and an enabled interrupt in RUN: the trap wins; WAIT is not entered.
- Reset in WAIT or HOLD → RUN next edge; WFIStallM drops the same edge.
- WFIStallM is registered-state-derived (a function of state only, not combinational on inputs), except the exit cycle, where it is deasserted combinationally.

Test Plan:
- Ecall in S mode (priv=01, InstrValidM=1, EcallFaultM=1, no ints) → TrapM=1, InterruptM=0, CauseM=9; next cycle state HOLD, TrapM=0.
- Priority: BreakpointFaultM=1, IllegalInstrFaultM=1, PendingIntsM=bit7, priv=M, MIE=1 → TrapM=1, InterruptM=1, CauseM=7.
  - Same stimulus with MIE=0 → InterruptM=0, CauseM=3.
- WFI wake: wfiM in RUN, no ints → WFIStallM=1 from the next cycle for 10 cycles. Then PendingIntsM=bit11 with priv=M, MIE=1 → TrapM=1, CauseM=11, WFIStallM=0, then HOLD, then RUN.
- WFI disabled wake: in WAIT, priv=M, MIE=0, PendingIntsM=bit3 → TrapM=0, WFIStallM=0 that cycle, state RUN next.
- WFI timeout: in WAIT, IllegalInstrFaultM=1 → TrapM=1, CauseM=2, InterruptM=0.
- Delegation and stall:
  - MIDELEG=bit9, PendingIntsM=bit9, priv=M → no trap.
  - priv=S, SIE=1 → CauseM=9.
  - StallW=1 with the same inputs → TrapM=0, state held.
  - Reset asserted in WAIT → all outputs 0 next cycle.
